instr_encoder: RTL and testbench
================================

# instr_encoder

- Sequential encoder that packs instruction fields into 32-bit MIPS instruction words and streams them into the instruction memory.
- Its opcode set is exactly the one the control decoder understands: R-type, BEQ, BNE, LW, SW, ADDI, J, LUI.
- It sits between the testbench/boot loader and instruction memory, so programs are built from fields rather than hand-assembled hex.
- Accepts one instruction per cycle over a valid/ready handshake, writes sequential addresses, and tracks fill level.

## Interface
- ADDR_W, 8, instruction memory address width; capacity 2**ADDR_W words.
- BASE_ADDR, 0, first write address; addresses wrap modulo 2**ADDR_W.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse; begins a program load from BASE_ADDR (honoured only in IDLE)
- finish  in  1  pulse; ends the load
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept this cycle
- op  in  3  class: 0 R, 1 BEQ, 2 BNE, 3 LW, 4 SW, 5 ADDI, 6 J, 7 LUI
- rs, rt, rd, shamt  in  5 each  register/shift fields
- funct  in  6  R-type function
- imm  in  16  immediate/offset
- target  in  26  jump target
- mem_we  out  1  write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written since start
- busy  out  1  not in IDLE
- full  out  1  count == 2**ADDR_W

## Operation
- FSM states: IDLE, LOAD, PAD, FULL.
- IDLE → LOAD on start. This clears count and sets the next address to BASE_ADDR.
- LOAD:
  - in_ready = 1.
  - An accept (in_valid & in_ready) registers the encoded word and the current address, then increments the address and count.
- Encoding, by op:
  - R: {000000, rs, rt, rd, shamt, funct}
  - BEQ: {000100, rs, rt, imm}
  - BNE: {000101, rs, rt, imm}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - J: {000010, target}
  - LUI: {001111, 00000, rt, imm}
- Fields not used by the selected format are ignored. LUI forces rs to zero.
- LOAD → FULL when the accept brings count to 2**ADDR_W.
  - In FULL, in_ready = 0 and in_valid is ignored.
  - finish → IDLE.
- LOAD → IDLE (or PAD, see Configuration) on finish.
  - If in_valid is also high that cycle, the word is accepted first.
- start outside IDLE is ignored. finish in IDLE is ignored.

## Timing
- Reset values: state IDLE; in_ready, mem_we, busy, full = 0; mem_addr, mem_wdata, count = 0.
- Latency: an accept in cycle N produces mem_we=1 in cycle N+1, with the mem_addr/mem_wdata of that word.
- Throughput: one word per cycle. No bubbles on back-to-back accepts.
- mem_we is high for exactly one cycle per word. When not writing, mem_addr/mem_wdata hold their last value.
- in_ready is combinational from state and full only; it never depends on in_valid.
- Cycle after start: busy = 1 and in_ready = 1.
- Cycle after the final accept: full = 1 and in_ready = 0.
- count updates in the same cycle mem_we is asserted.
- Reset mid-load: at the next edge everything returns to reset values, and a pending write is dropped (mem_we = 0).
- Address wrap: with BASE_ADDR ≠ 0, addresses wrap from 2**ADDR_W-1 to 0. full still triggers after 2**ADDR_W words.

## Configuration
- Macro: ENC_NOP_PAD_EN.
- When defined, finish in LOAD enters PAD instead of IDLE.
  - PAD writes 32'h0000_0000 (NOP) to each remaining address, one per cycle, with in_ready = 0.
  - PAD → IDLE after the write that makes count == 2**ADDR_W. full pulses high for that final cycle, then clears in IDLE.
  - finish with count already full goes directly to IDLE.
- When undefined, the PAD state does not exist. finish → IDLE, and busy drops the next cycle.

## Test plan
- R-type encode: start, then push add (op 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20) → next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, count=1.
- Back-to-back memory ops: push LW then SW (rs 29, rt 8, imm 4) in consecutive cycles → 0x8FA80004 @0, then 0xAFA80004 @1, mem_we high 2 cycles.
- Branch/immediate/jump formats:
  - BEQ (rs 1, rt 2, imm 0xFFFF) → 0x1022FFFF; BNE → 0x1422FFFF.
  - ADDI (rs 1, rt 2, imm 5) → 0x20220005.
  - J (target 0x10) → 0x08000010.
  - LUI (rs 7, rt 5, imm 0x1234) → 0x3C051234.
- Full, ADDR_W=2: 4 accepts → full=1, in_ready=0, count=4. A 5th in_valid produces no mem_we. finish → IDLE.
- Finish/pad, ADDR_W=2, 2 words then finish:
  - With ENC_NOP_PAD_EN: 0x00000000 written @2, @3, then IDLE.
  - Without ENC_NOP_PAD_EN: busy=0 next cycle, no further writes.
- Reset mid-load: rst_n=0 in the cycle after an accept → at the next edge, mem_we=0, count=0, state IDLE. start afterward writes from address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and streams them to instruction memory.
// Optional NOP padding of the unused memory tail on finish is enabled by defining ENC_NOP_PAD_EN.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full
);

    localparam logic [ADDR_W:0]   CAP   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_C = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

`ifdef ENC_NOP_PAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2, PAD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2} state_t;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_nxt;
    logic              clr;
    logic              vld_p0;
    logic [31:0]       word_p0;
    logic [ADDR_W:0]   cnt_inc;

    function automatic logic [31:0] encode(
        input logic [2:0]  o,
        input logic [4:0]  s,
        input logic [4:0]  t,
        input logic [4:0]  d,
        input logic [4:0]  sh,
        input logic [5:0]  fn,
        input logic [15:0] im,
        input logic [25:0] tg
    );
        logic [31:0] w;
        case (o)
            3'd0:    w = {6'b000000, s, t, d, sh, fn};
            3'd1:    w = {6'b000100, s, t, im};
            3'd2:    w = {6'b000101, s, t, im};
            3'd3:    w = {6'b100011, s, t, im};
            3'd4:    w = {6'b101011, s, t, im};
            3'd5:    w = {6'b001000, s, t, im};
            3'd6:    w = {6'b000010, tg};
            default: w = {6'b001111, 5'b00000, t, im};
        endcase
        return w;
    endfunction

    assign cnt_inc = count + ONE_C;

    // full stays visible for the cycle that writes the last word even if the FSM has already gone idle
    assign full     = (count == CAP) && ((state != IDLE) || mem_we);
    assign in_ready = (state == LOAD) && !full;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        vld_p0  = 1'b0;
        word_p0 = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    clr     = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    vld_p0  = 1'b1;
                    word_p0 = encode(op, rs, rt, rd, shamt, funct, imm, target);
                end
                if (finish) begin
`ifdef ENC_NOP_PAD_EN
                    state_n = (in_valid && cnt_inc == CAP) ? IDLE : PAD;
`else
                    state_n = IDLE;
`endif
                end else if (in_valid && cnt_inc == CAP) begin
                    state_n = FULL;
                end
            end
            FULL: begin
                if (finish) state_n = IDLE;
            end
`ifdef ENC_NOP_PAD_EN
            PAD: begin
                vld_p0 = 1'b1;
                if (cnt_inc == CAP) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // stage p0 -> memory write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            addr_nxt  <= '0;
        end else begin
            state  <= state_n;
            mem_we <= vld_p0;
            if (clr) begin
                count    <= '0;
                addr_nxt <= BASE;
            end else if (vld_p0) begin
                count     <= cnt_inc;
                addr_nxt  <= addr_nxt + ONE_A;
                mem_addr  <= addr_nxt;
                mem_wdata <= word_p0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spec cases plus randomized traffic against a reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic        a_in_ready, a_mem_we, a_busy, a_full;
    logic [1:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [2:0]  a_count;
    logic        b_in_ready, b_mem_we, b_busy, b_full;
    logic [2:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [3:0]  b_count;

    int checks = 0;
    int failures = 0;

`ifdef ENC_NOP_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(a_in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .count(a_count),
        .busy(a_busy), .full(a_full)
    );

    instr_encoder #(.ADDR_W(3), .BASE_ADDR(6)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
        .in_ready(b_in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .count(b_count),
        .busy(b_busy), .full(b_full)
    );

    // Reference model: a load session seen as "idle / accepting / saturated / padding"
    localparam int PH_IDLE = 0, PH_ACC = 1, PH_SAT = 2, PH_PADDING = 3;

    typedef struct packed {
        int          phase;
        int          cnt;
        int          nxt;
        bit          we;
        int          addr;
        logic [31:0] wdata;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic logic [31:0] ref_enc(input logic [2:0] o, input logic [4:0] s, t, d, sh,
                                            input logic [5:0] fn, input logic [15:0] im,
                                            input logic [25:0] tg);
        logic [5:0] opc;
        case (o)
            3'd0: opc = 6'h00;
            3'd1: opc = 6'h04;
            3'd2: opc = 6'h05;
            3'd3: opc = 6'h23;
            3'd4: opc = 6'h2B;
            3'd5: opc = 6'h08;
            3'd6: opc = 6'h02;
            default: opc = 6'h0F;
        endcase
        if (o == 3'd0) return {opc, s, t, d, sh, fn};
        if (o == 3'd6) return {opc, tg};
        if (o == 3'd7) return {opc, 5'd0, t, im};
        return {opc, s, t, im};
    endfunction

    function automatic mdl_t step(input mdl_t m, input int cap, input int base,
                                  input bit go, input bit fin, input bit vld,
                                  input logic [31:0] w);
        mdl_t n = m;
        n.we = 1'b0;
        if (m.phase == PH_IDLE) begin
            if (go) begin
                n.phase = PH_ACC;
                n.cnt = 0;
                n.nxt = base;
            end
        end else if (m.phase == PH_ACC) begin
            if (vld) begin
                n.we = 1'b1; n.addr = m.nxt; n.wdata = w;
                n.cnt = m.cnt + 1; n.nxt = (m.nxt + 1) % cap;
            end
            if (fin) n.phase = (PAD_ON && n.cnt < cap) ? PH_PADDING : PH_IDLE;
            else if (n.cnt == cap) n.phase = PH_SAT;
        end else if (m.phase == PH_SAT) begin
            if (fin) n.phase = PH_IDLE;
        end else begin
            n.we = 1'b1; n.addr = m.nxt; n.wdata = 32'h0;
            n.cnt = m.cnt + 1; n.nxt = (m.nxt + 1) % cap;
            if (n.cnt == cap) n.phase = PH_IDLE;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, 4, 0, start, finish, in_valid,
                       ref_enc(op, rs, rt, rd, shamt, funct, imm, target));
            mb <= step(mb, 8, 6, start, finish, in_valid,
                       ref_enc(op, rs, rt, rd, shamt, funct, imm, target));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] o, input logic [4:0] s, t, d, sh,
                       input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
    endtask

    task automatic put_rand;
        put(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), 16'($urandom), 26'($urandom));
    endtask

    task automatic drain(input bit fin);
        int n = 0;
        if (fin) begin
            finish = 1'b1; tick; finish = 1'b0;
        end
        while ((a_busy || b_busy) && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (a_busy || b_busy) begin
            failures++;
            $display("FAIL drain_idle a_busy=%0b b_busy=%0b want 0", a_busy, b_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        checks++;
        if ({a_in_ready, a_mem_we, a_busy, a_full} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {a_in_ready, a_mem_we, a_busy, a_full});
        end
        checks++;
        if ({a_mem_addr, a_mem_wdata, a_count} !== 37'b0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h count=%0d want 0", a_mem_addr, a_mem_wdata, a_count);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_rtype;
        start = 1'b1; tick; start = 1'b0;
        checks++;
        if ({a_busy, a_in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL after_start busy/in_ready got=%b want=11", {a_busy, a_in_ready});
        end
        put(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h3ABCDEF);
        in_valid = 1'b1; tick; in_valid = 1'b0;
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata, a_count} !== {1'b1, 2'd0, 32'h00221820, 3'd1}) begin
            failures++;
            $display("FAIL rtype we=%b addr=%0d wdata=%h count=%0d want 1/0/00221820/1",
                     a_mem_we, a_mem_addr, a_mem_wdata, a_count);
        end
        drain(1'b1);
    endtask

    task automatic test_back_to_back;
        start = 1'b1; tick; start = 1'b0;
        put(3'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        in_valid = 1'b1; tick;
        put(3'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 2'd0, 32'h8FA80004}) begin
            failures++;
            $display("FAIL b2b_lw we=%b addr=%0d wdata=%h want 1/0/8fa80004", a_mem_we, a_mem_addr, a_mem_wdata);
        end
        tick; in_valid = 1'b0;
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 2'd1, 32'hAFA80004}) begin
            failures++;
            $display("FAIL b2b_sw we=%b addr=%0d wdata=%h want 1/1/afa80004", a_mem_we, a_mem_addr, a_mem_wdata);
        end
        tick;
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata, a_count} !== {1'b0, 2'd1, 32'hAFA80004, 3'd2}) begin
            failures++;
            $display("FAIL b2b_hold we=%b addr=%0d wdata=%h count=%0d want 0/1/afa80004/2",
                     a_mem_we, a_mem_addr, a_mem_wdata, a_count);
        end
        drain(1'b1);
    endtask

    task automatic test_formats;
        logic [2:0]  fo [5]  = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
        logic [4:0]  fs [5]  = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd7};
        logic [4:0]  ft [5]  = '{5'd2, 5'd2, 5'd2, 5'd0, 5'd5};
        logic [15:0] fi [5]  = '{16'hFFFF, 16'hFFFF, 16'd5, 16'd0, 16'h1234};
        logic [31:0] fw [5]  = '{32'h1022FFFF, 32'h1422FFFF, 32'h20220005, 32'h08000010, 32'h3C051234};
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; tick; start = 1'b0;
            if (fo[i] == 3'd6)
                put(fo[i], 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                    16'($urandom), 26'h10);
            else
                put(fo[i], fs[i], ft[i], 5'($urandom), 5'($urandom), 6'($urandom), fi[i],
                    26'($urandom));
            in_valid = 1'b1; tick; in_valid = 1'b0;
            checks++;
            if ({a_mem_we, a_mem_wdata} !== {1'b1, fw[i]}) begin
                failures++;
                $display("FAIL format_%0d we=%b wdata=%h want 1/%h", i, a_mem_we, a_mem_wdata, fw[i]);
            end
            drain(1'b1);
        end
    endtask

    task automatic test_full;
        start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put_rand; tick;
        end
        checks++;
        if ({a_full, a_in_ready, a_count} !== {1'b1, 1'b0, 3'd4}) begin
            failures++;
            $display("FAIL full_reached full=%b in_ready=%b count=%0d want 1/0/4", a_full, a_in_ready, a_count);
        end
        put_rand; tick; in_valid = 1'b0;
        checks++;
        if ({a_mem_we, a_count, a_full} !== {1'b0, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL full_ignore we=%b count=%0d full=%b want 0/4/1", a_mem_we, a_count, a_full);
        end
        finish = 1'b1; tick; finish = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL full_finish busy=%b want 0", a_busy);
        end
        drain(1'b0);
    endtask

    task automatic test_finish_pad;
        start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1;
        put(3'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h7777, 26'd0); tick;
        put(3'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h8888, 26'd0); tick;
        in_valid = 1'b0;
        finish = 1'b1; tick; finish = 1'b0;
        if (PAD_ON) begin
            checks++;
            if ({a_busy, a_mem_we} !== 2'b10) begin
                failures++;
                $display("FAIL pad_enter busy/we got=%b want=10", {a_busy, a_mem_we});
            end
            tick;
            checks++;
            if ({a_mem_we, a_mem_addr, a_mem_wdata, a_count, a_full} !== {1'b1, 2'd2, 32'h0, 3'd3, 1'b0}) begin
                failures++;
                $display("FAIL pad_word2 we=%b addr=%0d wdata=%h count=%0d full=%b want 1/2/0/3/0",
                         a_mem_we, a_mem_addr, a_mem_wdata, a_count, a_full);
            end
            tick;
            checks++;
            if ({a_mem_we, a_mem_addr, a_mem_wdata, a_count, a_full, a_busy} !== {1'b1, 2'd3, 32'h0, 3'd4, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL pad_word3 we=%b addr=%0d wdata=%h count=%0d full=%b busy=%b want 1/3/0/4/1/0",
                         a_mem_we, a_mem_addr, a_mem_wdata, a_count, a_full, a_busy);
            end
            tick;
            checks++;
            if ({a_mem_we, a_full, a_busy} !== 3'b000) begin
                failures++;
                $display("FAIL pad_done we/full/busy got=%b want=000", {a_mem_we, a_full, a_busy});
            end
        end else begin
            checks++;
            if ({a_busy, a_mem_we} !== 2'b00) begin
                failures++;
                $display("FAIL nopad_finish busy/we got=%b want=00", {a_busy, a_mem_we});
            end
            tick;
            checks++;
            if ({a_mem_we, a_count, a_mem_wdata} !== {1'b0, 3'd2, 32'h20648888}) begin
                failures++;
                $display("FAIL nopad_quiet we=%b count=%0d wdata=%h want 0/2/20648888", a_mem_we, a_count, a_mem_wdata);
            end
        end
        drain(1'b0);
    endtask

    task automatic test_reset_midload;
        start = 1'b1; tick; start = 1'b0;
        put_rand; in_valid = 1'b1; tick; in_valid = 1'b0;
        rst_n = 1'b0; tick;
        checks++;
        if ({a_mem_we, a_count, a_busy, a_mem_addr, a_mem_wdata} !== 38'b0) begin
            failures++;
            $display("FAIL midreset we=%b count=%0d busy=%b addr=%0d wdata=%h want all 0",
                     a_mem_we, a_count, a_busy, a_mem_addr, a_mem_wdata);
        end
        rst_n = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        put_rand; in_valid = 1'b1; tick; in_valid = 1'b0;
        checks++;
        if ({a_mem_we, a_mem_addr, a_count, b_mem_addr} !== {1'b1, 2'd0, 3'd1, 3'd6}) begin
            failures++;
            $display("FAIL restart we=%b a_addr=%0d count=%0d b_addr=%0d want 1/0/1/6",
                     a_mem_we, a_mem_addr, a_count, b_mem_addr);
        end
        drain(1'b1);
    endtask

    task automatic test_wrap;
        start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put_rand; tick;
            checks++;
            if ({b_mem_we, b_mem_addr} !== {1'b1, 3'((6 + i) % 8)}) begin
                failures++;
                $display("FAIL wrap_addr_%0d we=%b addr=%0d want 1/%0d", i, b_mem_we, b_mem_addr, (6 + i) % 8);
            end
        end
        in_valid = 1'b0;
        checks++;
        if ({b_full, b_in_ready, b_count} !== {1'b1, 1'b0, 4'd8}) begin
            failures++;
            $display("FAIL wrap_full full=%b in_ready=%b count=%0d want 1/0/8", b_full, b_in_ready, b_count);
        end
        drain(1'b1);
    endtask

    task automatic test_random;
        logic [2:0] ea_ctl, eb_ctl;
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 79) != 0);
            start    = ($urandom_range(0, 7) == 0);
            finish   = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            put_rand;
            tick;
            ea_ctl = {ma.phase == PH_ACC, ma.phase != PH_IDLE, ma.cnt == 4 && (ma.phase != PH_IDLE || ma.we)};
            eb_ctl = {mb.phase == PH_ACC, mb.phase != PH_IDLE, mb.cnt == 8 && (mb.phase != PH_IDLE || mb.we)};
            checks++;
            if ({a_in_ready, a_busy, a_full, a_mem_we, a_count} !== {ea_ctl, ma.we, 3'(ma.cnt)}) begin
                failures++;
                $display("FAIL rand_a_ctl cyc=%0d got=%b want=%b", c,
                         {a_in_ready, a_busy, a_full, a_mem_we, a_count}, {ea_ctl, ma.we, 3'(ma.cnt)});
            end
            checks++;
            if ({a_mem_addr, a_mem_wdata} !== {2'(ma.addr), ma.wdata}) begin
                failures++;
                $display("FAIL rand_a_data cyc=%0d addr=%0d wdata=%h want %0d/%h", c,
                         a_mem_addr, a_mem_wdata, ma.addr, ma.wdata);
            end
            checks++;
            if ({b_in_ready, b_busy, b_full, b_mem_we, b_count} !== {eb_ctl, mb.we, 4'(mb.cnt)}) begin
                failures++;
                $display("FAIL rand_b_ctl cyc=%0d got=%b want=%b", c,
                         {b_in_ready, b_busy, b_full, b_mem_we, b_count}, {eb_ctl, mb.we, 4'(mb.cnt)});
            end
            checks++;
            if ({b_mem_addr, b_mem_wdata} !== {3'(mb.addr), mb.wdata}) begin
                failures++;
                $display("FAIL rand_b_data cyc=%0d addr=%0d wdata=%h want %0d/%h", c,
                         b_mem_addr, b_mem_wdata, mb.addr, mb.wdata);
            end
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; finish = 1'b0;
        drain(1'b1);
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_back_to_back;
        test_formats;
        test_full;
        test_finish_pad;
        test_reset_midload;
        test_wrap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
